// File: rtl/param_counter_aasd.sv
// ----------------------------------------------------------------------------
// param_counter_aasd
//   Up/down modulo-(MAX_VAL+1) counter with a built-in reset synchroniser
//   (asynchronous assert, synchronous deassert). The synchroniser output
//   asynchronously resets the counter flops and is also exported for
//   downstream blocks.
//
// Parameters
//   WIDTH        counter / DATA width in bits (>= 2)
//   MAX_VAL      terminal value; count range is 0..MAX_VAL
//   SYNC_STAGES  flops in the reset-deassert synchroniser (>= 2)
//   SATURATE     0: wrap at the limits, 1: hold at the limits
//
// Ports
//   CLOCK       in   rising-edge clock
//   RESET       in   asynchronous active-low reset
//   ENABLE      in   count enable, one step per enabled cycle
//   LOAD        in   synchronous load of DATA (clamped to MAX_VAL)
//   UP_DOWN     in   1: count up, 0: count down
//   DATA        in   load value
//   COUNT       out  registered count
//   TC          out  registered one-cycle terminal-count pulse
//   RST_SYNC_N  out  synchronised active-low reset
// ----------------------------------------------------------------------------
module param_counter_aasd #(
  parameter int WIDTH       = 8,
  parameter int MAX_VAL     = 255,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             LOAD,
  input  logic             UP_DOWN,
  input  logic [WIDTH-1:0] DATA,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             RST_SYNC_N
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] LP_MIN = '0;

  // --------------------------------------------------------------------------
  // Reset synchroniser: a 1 enters at stage 0 once RESET is released and
  // reaches the last stage after SYNC_STAGES rising edges.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rst_sync_n;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours, as real hardware does.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_rst_sync_n = r_sync[SYNC_STAGES-1];
  assign RST_SYNC_N   = w_rst_sync_n;

  // --------------------------------------------------------------------------
  // Next-state logic. Limits are compared explicitly so that the full-range
  // case (MAX_VAL = 2**WIDTH-1) behaves the same as any other modulus.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_tc;
  logic [WIDTH-1:0] w_load_val;
  logic             w_at_max;
  logic             w_at_min;

  assign w_load_val = (DATA > LP_MAX) ? LP_MAX : DATA;
  assign w_at_max   = (r_count == LP_MAX);
  assign w_at_min   = (r_count == LP_MIN);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_count = r_count;
    w_next_tc    = 1'b0;
    if (LOAD) begin
      w_next_count = w_load_val;
    end else if (ENABLE) begin
      if (UP_DOWN) begin
        if (w_at_max) begin
          w_next_tc = 1'b1;
          if (SATURATE == 0) begin
            w_next_count = LP_MIN;
          end
        end else begin
          w_next_count = r_count + 1'b1;
        end
      end else begin
        if (w_at_min) begin
          w_next_tc = 1'b1;
          if (SATURATE == 0) begin
            w_next_count = LP_MAX;
          end
        end else begin
          w_next_count = r_count - 1'b1;
        end
      end
    end
  end

  // NOTE: the counter is reset by the synchronised reset, not raw RESET, so
  // its release is aligned to CLOCK; assertion is still immediate because the
  // synchroniser clears asynchronously.
  always_ff @(posedge CLOCK or negedge w_rst_sync_n) begin
    if (!w_rst_sync_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_tc    <= w_next_tc;
    end
  end

  assign COUNT = r_count;
  assign TC    = r_tc;

endmodule

// File: tb/tb_param_counter_aasd.sv
// ----------------------------------------------------------------------------
// tb_param_counter_aasd
//   Three instances share one stimulus stream:
//     dut 0 : WIDTH=8, MAX_VAL=255, SYNC_STAGES=2, SATURATE=0
//     dut 1 : WIDTH=8, MAX_VAL=255, SYNC_STAGES=2, SATURATE=1
//     dut 2 : WIDTH=8, MAX_VAL=9,   SYNC_STAGES=3, SATURATE=0
//   A behavioural model per instance tracks edges-since-reset-release, the
//   count as an integer and the terminal-count flag.
// ----------------------------------------------------------------------------
module tb_param_counter_aasd;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       ENABLE;
  logic       LOAD;
  logic       UP_DOWN;
  logic [7:0] DATA;

  logic [7:0] cnt [3];
  logic       tc  [3];
  logic       rsn [3];

  int n_total = 0;
  int n_bad   = 0;

  // Model state and per-instance configuration.
  int p_max    [3] = '{255, 255, 9};
  int p_sat    [3] = '{0, 1, 0};
  int p_stages [3] = '{2, 2, 3};
  int m_edges  [3];
  int m_cnt    [3];
  int m_tc     [3];

  always #5 CLOCK = ~CLOCK;

  param_counter_aasd #(.WIDTH(8), .MAX_VAL(255), .SYNC_STAGES(2), .SATURATE(0)) u_dut0 (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .LOAD(LOAD), .UP_DOWN(UP_DOWN),
    .DATA(DATA), .COUNT(cnt[0]), .TC(tc[0]), .RST_SYNC_N(rsn[0]));

  param_counter_aasd #(.WIDTH(8), .MAX_VAL(255), .SYNC_STAGES(2), .SATURATE(1)) u_dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .LOAD(LOAD), .UP_DOWN(UP_DOWN),
    .DATA(DATA), .COUNT(cnt[1]), .TC(tc[1]), .RST_SYNC_N(rsn[1]));

  param_counter_aasd #(.WIDTH(8), .MAX_VAL(9), .SYNC_STAGES(3), .SATURATE(0)) u_dut2 (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .LOAD(LOAD), .UP_DOWN(UP_DOWN),
    .DATA(DATA), .COUNT(cnt[2]), .TC(tc[2]), .RST_SYNC_N(rsn[2]));

  task automatic check(string tag, int obs, int exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s.dut%0d.count", tag, k), int'(cnt[k]), m_cnt[k]);
      check($sformatf("%s.dut%0d.tc", tag, k), int'(tc[k]), m_tc[k]);
      check($sformatf("%s.dut%0d.rsn", tag, k), int'(rsn[k]),
            (m_edges[k] >= p_stages[k]) ? 1 : 0);
    end
  endtask

  // RESET falling: everything clears at once.
  task automatic drop_reset();
    RESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_edges[k] = 0;
      m_cnt[k]   = 0;
      m_tc[k]    = 0;
    end
  endtask

  // Effect of one rising edge on instance k, from the behavioural rules.
  function automatic void model_edge(int k);
    if (m_edges[k] >= p_stages[k]) begin
      m_tc[k] = 0;
      if (LOAD) begin
        m_cnt[k] = (int'(DATA) > p_max[k]) ? p_max[k] : int'(DATA);
      end else if (ENABLE && UP_DOWN) begin
        if (m_cnt[k] == p_max[k]) begin
          m_tc[k] = 1;
          if (p_sat[k] == 0) m_cnt[k] = 0;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end else if (ENABLE) begin
        if (m_cnt[k] == 0) begin
          m_tc[k] = 1;
          if (p_sat[k] == 0) m_cnt[k] = p_max[k];
        end else begin
          m_cnt[k] = m_cnt[k] - 1;
        end
      end
    end
    if (RESET && m_edges[k] < 1000) m_edges[k] = m_edges[k] + 1;
  endfunction

  // Advance one edge, then check every instance 1 time unit later.
  task automatic tick(string tag);
    @(posedge CLOCK);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    check_all(tag);
  endtask

  task automatic set_in(logic ld, logic en, logic up, logic [7:0] d);
    LOAD = ld; ENABLE = en; UP_DOWN = up; DATA = d;
  endtask

  initial begin
    RESET = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    drop_reset();
    #1;
    check_all("reset");
    tick("reset_hold");

    // Release with counting requested: counting starts only once the
    // synchronised reset is high.
    set_in(1'b0, 1'b1, 1'b1, 8'h00);
    RESET = 1'b1;
    for (int i = 0; i < 5; i++) tick($sformatf("release%0d", i));
    check("release.dut0.count_const", int'(cnt[0]), 3);

    // Load near the top and count up across the limit.
    set_in(1'b1, 1'b0, 1'b1, 8'hFE);
    tick("load_fe");
    set_in(1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) tick($sformatf("wrap_up%0d", i));
    check("wrap.dut0.count_const", int'(cnt[0]), 1);

    // Count down from 1 across the bottom limit.
    set_in(1'b1, 1'b0, 1'b0, 8'd1);
    tick("load_1");
    set_in(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) tick($sformatf("sat_down%0d", i));
    check("sat.dut1.tc_const", int'(tc[1]), 1);

    // Clamped load, then up and down over the small modulus.
    set_in(1'b1, 1'b0, 1'b0, 8'd200);
    tick("load_200");
    check("clamp.dut2.count_const", int'(cnt[2]), 9);
    set_in(1'b0, 1'b1, 1'b1, 8'h00);
    tick("mod_up");
    set_in(1'b0, 1'b1, 1'b0, 8'h00);
    tick("mod_down");

    // LOAD wins over a step issued at the limit.
    set_in(1'b1, 1'b0, 1'b0, 8'hFF);
    tick("load_ff");
    set_in(1'b1, 1'b1, 1'b1, 8'd5);
    tick("load_vs_step");
    check("loadwin.dut0.tc_const", int'(tc[0]), 0);

    // Asynchronous reset between edges.
    set_in(1'b1, 1'b0, 1'b0, 8'd77);
    tick("load_77");
    set_in(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    drop_reset();
    #1;
    check_all("async_rst");
    tick("async_rst_hold");
    RESET = 1'b1;

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom));
      if ($urandom_range(0, 99) < 3) drop_reset();
      else RESET = 1'b1;
      tick($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
